// File: rtl/grostl_round_ctrl.sv
// Groestl round/column sequencer: issues P (then Q) column addresses per round with a SYNC bubble between rounds.
// Define GROSTL_OUTPUT_XFORM_EN to enable the P-only output-transform run selected by final_in.
module grostl_round_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       final_in,
    input  logic       stall,
    output logic       pq,
    output logic [3:0] rnd,
    output logic [2:0] col,
    output logic       col_valid,
    output logic       busy,
    output logic       done
);

    // IDLE: wait for start | RUN: issue columns | SYNC: one-cycle MixBytes bubble | DONE: done pulse
    typedef enum logic [1:0] {IDLE, RUN, SYNC, DONE} state_t;

    state_t     state_q;
    logic       p_only_q;
    logic [3:0] rnd_cnt_q;
    logic       pq_q;
    logic [3:0] rnd_q;
    logic [2:0] col_q;
    logic       col_valid_q;
    logic       busy_q;
    logic       done_q;
    logic       start_p_only;
    logic [3:0] rnd_next_d;

`ifdef GROSTL_OUTPUT_XFORM_EN
    assign start_p_only = final_in;
`else
    logic unused_final_in;
    assign unused_final_in = final_in;
    assign start_p_only    = 1'b0;
`endif

    assign rnd_next_d = rnd_cnt_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            p_only_q    <= 1'b0;
            rnd_cnt_q   <= 4'd0;
            pq_q        <= 1'b0;
            rnd_q       <= 4'd0;
            col_q       <= 3'd0;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        p_only_q    <= start_p_only;
                        rnd_cnt_q   <= 4'd0;
                        pq_q        <= 1'b0;
                        rnd_q       <= 4'd0;
                        col_q       <= 3'd0;
                        col_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (col_q != 3'd7) begin
                            col_q <= col_q + 3'd1;
                        end else if (!pq_q && !p_only_q) begin
                            pq_q  <= 1'b1;
                            col_q <= 3'd0;
                        end else begin
                            // Last column of the round: addresses read as zero outside RUN.
                            pq_q        <= 1'b0;
                            rnd_q       <= 4'd0;
                            col_q       <= 3'd0;
                            col_valid_q <= 1'b0;
                            if (rnd_cnt_q != 4'd9) begin
                                state_q <= SYNC;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                SYNC: begin
                    state_q     <= RUN;
                    rnd_cnt_q   <= rnd_next_d;
                    rnd_q       <= rnd_next_d;
                    col_valid_q <= 1'b1;
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    p_only_q  <= 1'b0;
                    rnd_cnt_q <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pq        = pq_q;
    assign rnd       = rnd_q;
    assign col       = col_q;
    assign col_valid = col_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_grostl_round_ctrl.sv
// Scoreboard bench for grostl_round_ctrl: a slot-list model predicts column order and done timing.
module tb_grostl_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       final_in = 1'b0;
    logic       stall = 1'b0;
    logic       pq;
    logic [3:0] rnd;
    logic [2:0] col;
    logic       col_valid;
    logic       busy;
    logic       done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int bubbles = 0;
    int cols_q[$];
    int st_q[$];
    int dc_q[$];

    grostl_round_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .final_in(final_in), .stall(stall),
        .pq(pq), .rnd(rnd), .col(col), .col_valid(col_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected columns on acceptance and expected done timing on the done pulse.
    always @(negedge clk) begin
        if (reset) begin
            bubbles = 0;
        end else begin
            chk("busy", int'(busy), int'(dc_q.size() > 0 && cyc >= st_q[0]));
            if (col_valid) begin
                chk("col_expected", int'(cols_q.size() != 0), 1);
                if (cols_q.size() != 0) begin
                    chk("col_addr", int'({pq, rnd, col}), cols_q[0]);
                    if (!stall) void'(cols_q.pop_front());
                end
            end else begin
                chk("idle_zero", int'({pq, rnd, col}), 0);
                if (busy && !done) bubbles++;
            end
            if (done) begin
                chk("done_expected", int'(dc_q.size() != 0), 1);
                if (dc_q.size() != 0) begin
                    chk("done_cycle", cyc, dc_q.pop_front());
                    void'(st_q.pop_front());
                    chk("cols_left", cols_q.size(), 0);
                    chk("sync_bubbles", bubbles, 9);
                end
                bubbles = 0;
            end
        end
    end

    task automatic drive_misc(input int mode, input bit noise, input int s0);
        int cy;
        cy = cyc - s0 + 1;
        if (mode == 4) begin
            start = (cy == 50 || cy == 170);
        end else if (noise) begin
            start    = ($urandom_range(0, 9) == 0);
            final_in = $urandom_range(0, 1);
        end else begin
            start = 1'b0;
        end
    endtask

    // mode: 0 no stall, 1 stall 3 at r4/Q/c5, 2 stall around SYNC after round 2, 3 random, 4 start pulses mid-run
    task automatic run_one(input bit f, input int mode, input bit noise, input int abort_at);
        bit po;
        int nom, extra, s0, k;
        int kind[$];
        int tag[$];
        int nst[$];
`ifdef GROSTL_OUTPUT_XFORM_EN
        po = f;
`else
        po = 1'b0;
`endif
        nom   = po ? 90 : 170;
        extra = 0;
        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < (po ? 1 : 2); p++) begin
                for (int c = 0; c < 8; c++) begin
                    kind.push_back(0);
                    tag.push_back(p * 128 + r * 8 + c);
                    cols_q.push_back(p * 128 + r * 8 + c);
                end
            end
            if (r < 9) begin
                kind.push_back(1);
                tag.push_back(r);
            end
        end
        for (int i = 0; i < kind.size(); i++) begin
            k = 0;
            if (kind[i] == 0) begin
                if (mode == 1 && tag[i] == 128 + 4 * 8 + 5) k = 3;
                if (mode == 2 && i + 1 < kind.size() && kind[i+1] == 1 && tag[i+1] == 2) k = 2;
                if (mode == 2 && tag[i] == 3 * 8) k = 1;
                if (mode == 3 && $urandom_range(0, 7) == 0) k = $urandom_range(1, 3);
            end
            nst.push_back(k);
            extra += k;
        end

        start    = 1'b1;
        final_in = f;
        tick();
        start    = 1'b0;
        final_in = 1'b0;
        s0       = cyc;
        st_q.push_back(s0);
        dc_q.push_back(s0 + nom - 1 + extra);

        for (int i = 0; i < kind.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_zero", int'({col_valid, busy, done, pq, rnd, col}), 0);
                cols_q.delete();
                st_q.delete();
                dc_q.delete();
                start = 1'b0;
                stall = 1'b0;
                tick();
                reset = 1'b0;
                repeat (4) tick();
                return;
            end
            if (kind[i] == 0) begin
                for (int j = 0; j < nst[i]; j++) begin
                    stall = 1'b1;
                    drive_misc(mode, noise, s0);
                    tick();
                end
                stall = 1'b0;
                drive_misc(mode, noise, s0);
                tick();
            end else begin
                stall = (mode == 2 && tag[i] == 2) ? 1'b1 : 1'(($urandom_range(0, 1)));
                drive_misc(mode, noise, s0);
                tick();
            end
        end
        stall = 1'($urandom_range(0, 1));
        drive_misc(mode, noise, s0);
        tick();
        start    = 1'b0;
        final_in = 1'b0;
        stall    = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        chk("reset_state", int'({col_valid, busy, done, pq, rnd, col}), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();

        run_one(1'b0, 0, 1'b0, -1);
        run_one(1'b1, 0, 1'b0, -1);
        run_one(1'b0, 1, 1'b0, -1);
        run_one(1'b0, 4, 1'b0, -1);
        run_one(1'b0, 0, 1'b0, 6 * 17 + 3);
        run_one(1'b0, 0, 1'b0, -1);
        run_one(1'b0, 2, 1'b0, -1);
        run_one(1'b1, 2, 1'b0, -1);
        for (int n = 0; n < 6; n++) begin
            run_one(1'($urandom_range(0, 1)), 3, 1'b1, -1);
        end

        repeat (3) tick();
        chk("final_cols_empty", cols_q.size(), 0);
        chk("final_done_empty", dc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grostl_round_ctrl.md
GROSTL_ROUND_CTRL -- requirements
Module: grostl_round_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: a single-cycle request to begin one permutation run.
REQ-004 The block SHALL have port final_in, input, 1 bit: selects a P-only output-transform run; it is sampled together with start.
REQ-005 The block SHALL have port stall, input, 1 bit: when high, the datapath does not accept the current column.
REQ-006 The block SHALL have port pq, output, 1 bit: 0 = P permutation, 1 = Q permutation; it drives the add-constant pq select.
REQ-007 The block SHALL have port rnd, output, 4 bits: the current round index, 0..9.
REQ-008 The block SHALL have port col, output, 3 bits: the current column index, 0..7.
REQ-009 The block SHALL have port col_valid, output, 1 bit: pq/rnd/col address a live column this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the run completes.

Function
REQ-012 The block SHALL implement the states IDLE, RUN, SYNC and DONE.
REQ-013 IDLE: start=1 SHALL go to RUN with rnd=0, col=0, pq=0; it SHALL latch final_in into p_only.
REQ-014 In IDLE, start=0 SHALL keep the block in IDLE, with outputs as given in REQ-024.
REQ-015 RUN SHALL drive col_valid=1; a column is accepted on a cycle with col_valid=1 and stall=0.
REQ-016 In RUN, stall=1 SHALL hold pq, rnd and col unchanged, with col_valid held at 1.
REQ-017 Column order within a round SHALL be P col 0..7, then Q col 0..7; if p_only=1, Q is skipped.
REQ-018 On acceptance of col<7, col SHALL increment by 1 with pq unchanged.
REQ-019 On acceptance of P col 7 with p_only=0, the block SHALL set pq=1 and col=0.
REQ-020 On acceptance of the last column of a round (Q col 7, or P col 7 if p_only=1), the block SHALL go to SYNC if rnd<9, else to DONE.
REQ-021 SYNC SHALL last exactly one cycle with col_valid=0, ignoring stall; it SHALL then enter RUN with rnd+1, col=0, pq=0.
REQ-022 The SYNC bubble SHALL separate rounds so the datapath completes MixBytes before the next round begins.
REQ-023 DONE SHALL last one cycle with done=1 and col_valid=0, then return to IDLE.
REQ-024 Whenever col_valid=0, pq, rnd and col SHALL be 0.
REQ-025 The col counter SHALL never wrap from 7 to 0 without also updating pq or the state; rnd SHALL never exceed 9.
REQ-026 With no stalls, done SHALL occur 170 cycles after the start edge when p_only=0, and 90 cycles after it when p_only=1; each stall cycle adds 1.
REQ-027 start SHALL be ignored while busy=1; a start in the DONE cycle is also ignored.
REQ-028 final_in SHALL be ignored outside the start-accept cycle.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, p_only=0, pq=0, rnd=0, col=0, col_valid=0, busy=0 and done=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-031 After reset deasserts, the block SHALL wait in IDLE for a new start.

Configuration
REQ-032 The macro GROSTL_OUTPUT_XFORM_EN SHALL control the P-only output-transform feature.
REQ-033 With GROSTL_OUTPUT_XFORM_EN defined, final_in SHALL behave as in REQ-013, REQ-017, REQ-020 and REQ-026.
REQ-034 Without GROSTL_OUTPUT_XFORM_EN, final_in SHALL remain a port but be ignored, and p_only SHALL be constant 0, so every run is P+Q with done at 170 cycles.

Verification
REQ-035 The bench SHALL cover: reset, start with final_in=0 and stall=0 -> col_valid sequence P0..7,Q0..7 per round, 9 SYNC bubbles, done at cycle 170, busy=1 from cycles 1..170.
REQ-036 The bench SHALL cover: start with final_in=1 and the macro defined -> pq always 0, done at cycle 90; with the macro undefined -> done at cycle 170 and Q columns present.
REQ-037 The bench SHALL cover: stall=1 for 3 cycles at rnd=4, pq=1, col=5 -> outputs frozen at 4/1/5 with col_valid=1, done at cycle 173.
REQ-038 The bench SHALL cover: start pulsed at cycles 50 and 170 during a run -> no restart, single done at 170, then IDLE.
REQ-039 The bench SHALL cover: reset asserted at rnd=6 -> all outputs 0 immediately, no done, and a new start yields a full 170-cycle run.
REQ-040 The bench SHALL cover: stall=1 held across a SYNC cycle -> SYNC still lasts 1 cycle and RUN resumes with rnd incremented and col_valid=1.
